irig_bit_classifier: RTL and testbench

IRIG_BIT_CLASSIFIER -- requirements
Module: irig_bit_classifier

---
 rtl/irig_bit_classifier.sv | 215 +++++++++++++++++++++
 tb/tb_irig_bit_classifier.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irig_bit_classifier.sv
// IRIG-B DC-level bit classifier.
// Measures the high width of each pulse on the synchronized irigb input and
// classifies it as D0, D1 or MARK, flags unclassifiable pulses (too short or
// stuck high), and marks the reference marker Pr (MARK after MARK).
// Optional build macro: IRIG_GLITCH_FILTER_EN adds a 3-sample majority filter
// after the synchronizer (2 extra cycles of latency, 1-cycle glitches removed).
module irig_bit_classifier #(
  parameter int T_MIN = 10000,
  parameter int T_01  = 35000,
  parameter int T_1M  = 65000,
  parameter int T_MAX = 95000
) (
  input  logic       clk_10mhz,
  input  logic       rst_n,
  input  logic       irigb,
  output logic       sym_valid,
  output logic [1:0] sym,
  output logic       sym_err,
  output logic       frame_start
);

  localparam logic [16:0] T_MIN_C = 17'(T_MIN);
  localparam logic [16:0] T_01_C  = 17'(T_01);
  localparam logic [16:0] T_1M_C  = 17'(T_1M);
  localparam logic [16:0] T_MAX_C = 17'(T_MAX);

  localparam logic [1:0] SYM_D0   = 2'b00;
  localparam logic [1:0] SYM_D1   = 2'b01;
  localparam logic [1:0] SYM_MARK = 2'b10;

  // ST_WAIT_LOW: after reset, ignore any pulse already in progress until the
  // line is seen low with a fully primed synchronizer chain.
  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'b00,
    ST_IDLE     = 2'b01,
    ST_HIGH     = 2'b10
  } state_t;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic         sync1_r;
  logic         sync2_r;
  logic         irig_s;
  logic [2:0]   prime_r;
  logic         primed_s;

  state_t       state_r,       state_nxt;
  logic [16:0]  cnt_r,         cnt_nxt;
  logic         sym_valid_r,   sym_valid_nxt;
  logic [1:0]   sym_r,         sym_nxt;
  logic         sym_err_r,     sym_err_nxt;
  logic         frame_start_r, frame_start_nxt;
  logic         prev_mark_r,   prev_mark_nxt;

  // Two-flop synchronizer for the asynchronous IRIG-B input.
  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= irigb;
      sync2_r <= sync1_r;
    end
  end

`ifdef IRIG_GLITCH_FILTER_EN
  // Filter output is trustworthy only once the history taps are refilled.
  localparam logic [2:0] PRIME_CYC = 3'd5;

  logic hist1_r;
  logic hist2_r;
  logic filt_r;

  // Majority filter over the last three synchronized samples.
  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      hist1_r <= 1'b0;
      hist2_r <= 1'b0;
      filt_r  <= 1'b0;
    end else begin
      hist1_r <= sync2_r;
      hist2_r <= hist1_r;
      filt_r  <= maj3(sync2_r, hist1_r, hist2_r);
    end
  end

  assign irig_s = filt_r;
`else
  // Synchronizer output reflects the line two cycles after reset release.
  localparam logic [2:0] PRIME_CYC = 3'd2;

  assign irig_s = sync2_r;
`endif

  // Count cycles after reset until irig_s reflects the real line level.
  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      prime_r <= 3'd0;
    end else if (prime_r != PRIME_CYC) begin
      prime_r <= prime_r + 3'd1;
    end else begin
      prime_r <= prime_r;
    end
  end

  assign primed_s = (prime_r == PRIME_CYC);

  // State, width counter and registered outputs.
  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_WAIT_LOW;
      cnt_r         <= 17'd0;
      sym_valid_r   <= 1'b0;
      sym_r         <= SYM_D0;
      sym_err_r     <= 1'b0;
      frame_start_r <= 1'b0;
      prev_mark_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      cnt_r         <= cnt_nxt;
      sym_valid_r   <= sym_valid_nxt;
      sym_r         <= sym_nxt;
      sym_err_r     <= sym_err_nxt;
      frame_start_r <= frame_start_nxt;
      prev_mark_r   <= prev_mark_nxt;
    end
  end

  // Pulse measurement, classification and stuck-high detection.
  always_comb begin
    state_nxt       = state_r;
    cnt_nxt         = cnt_r;
    sym_valid_nxt   = 1'b0;
    sym_nxt         = sym_r;
    sym_err_nxt     = 1'b0;
    frame_start_nxt = 1'b0;
    prev_mark_nxt   = prev_mark_r;

    case (state_r)
      ST_WAIT_LOW: begin
        cnt_nxt = 17'd0;
        if (primed_s && !irig_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_LOW;
        end
      end

      ST_IDLE: begin
        if (irig_s) begin
          // Rising cycle is itself the first high cycle.
          state_nxt = ST_HIGH;
          cnt_nxt   = 17'd1;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 17'd0;
        end
      end

      ST_HIGH: begin
        if (irig_s) begin
          if (cnt_r < T_MAX_C) begin
            cnt_nxt = cnt_r + 17'd1;
            if (cnt_r == (T_MAX_C - 17'd1)) begin
              // Stuck high: report once, counter then saturates.
              sym_err_nxt   = 1'b1;
              prev_mark_nxt = 1'b0;
            end else begin
              sym_err_nxt   = 1'b0;
            end
          end else begin
            cnt_nxt = cnt_r;
          end
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 17'd0;
          if (cnt_r >= T_MAX_C) begin
            // Already reported as stuck; the late falling edge is silent.
            sym_err_nxt = 1'b0;
          end else if (cnt_r < T_MIN_C) begin
            sym_err_nxt   = 1'b1;
            prev_mark_nxt = 1'b0;
          end else if (cnt_r < T_01_C) begin
            sym_valid_nxt = 1'b1;
            sym_nxt       = SYM_D0;
            prev_mark_nxt = 1'b0;
          end else if (cnt_r < T_1M_C) begin
            sym_valid_nxt = 1'b1;
            sym_nxt       = SYM_D1;
            prev_mark_nxt = 1'b0;
          end else begin
            sym_valid_nxt   = 1'b1;
            sym_nxt         = SYM_MARK;
            frame_start_nxt = prev_mark_r;
            prev_mark_nxt   = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_WAIT_LOW;
        cnt_nxt   = 17'd0;
      end
    endcase
  end

  assign sym_valid   = sym_valid_r;
  assign sym         = sym_r;
  assign sym_err     = sym_err_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_irig_bit_classifier.sv
// Self-checking bench for irig_bit_classifier. Thresholds are scaled down
// by 100 so that millisecond-scale scenarios stay short.
`timescale 1ns/1ps
module tb_irig_bit_classifier;

  localparam int T_MIN = 100;
  localparam int T_01  = 350;
  localparam int T_1M  = 650;
  localparam int T_MAX = 950;
`ifdef IRIG_GLITCH_FILTER_EN
  localparam int LAT      = 5;
  localparam int MIN_SEEN = 2;
`else
  localparam int LAT      = 3;
  localparam int MIN_SEEN = 1;
`endif

  logic       clk_10mhz = 1'b0;
  logic       rst_n;
  logic       irigb;
  logic       sym_valid;
  logic [1:0] sym;
  logic       sym_err;
  logic       frame_start;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [1:0] sym;
    logic       fs;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         overlap_cnt = 0;
  int         hold_viol_cnt = 0;
  int         orphan_fs_cnt = 0;
  logic [1:0] last_sym = 2'b00;
  bit         model_prev_mark = 1'b0;

  irig_bit_classifier #(
    .T_MIN(T_MIN), .T_01(T_01), .T_1M(T_1M), .T_MAX(T_MAX)
  ) dut (
    .clk_10mhz  (clk_10mhz),
    .rst_n      (rst_n),
    .irigb      (irigb),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .sym_err    (sym_err),
    .frame_start(frame_start)
  );

  always #50 clk_10mhz = ~clk_10mhz;

  always @(posedge clk_10mhz) cyc <= cyc + 1;

  // Record every strobe and any protocol anomaly on the falling edge.
  initial begin
    forever begin
      @(negedge clk_10mhz);
      if (!rst_n) begin
        last_sym = 2'b00;
      end else begin
        if (sym_valid && sym_err) overlap_cnt++;
        if (!sym_valid && sym !== last_sym) hold_viol_cnt++;
        if (frame_start && !sym_valid) orphan_fs_cnt++;
        if (sym_valid) begin
          obs_q.push_back('{cyc, 1'b0, sym, frame_start});
          last_sym = sym;
        end else if (sym_err) begin
          obs_q.push_back('{cyc, 1'b1, sym, frame_start});
        end
      end
    end
  end

  // Reference model: what one pulse of w high cycles must produce.
  task automatic model_pulse(input int w, input int r, input int f);
    ev_t e;
    if (w < MIN_SEEN) return;
    e.fs  = 1'b0;
    e.sym = 2'b00;
    if (w >= T_MAX) begin
      e.cyc = r + T_MAX + LAT - 1;
      e.is_err = 1'b1;
      model_prev_mark = 1'b0;
    end else if (w < T_MIN) begin
      e.cyc = f + LAT;
      e.is_err = 1'b1;
      model_prev_mark = 1'b0;
    end else begin
      e.cyc = f + LAT;
      e.is_err = 1'b0;
      e.sym = (w < T_01) ? 2'b00 : ((w < T_1M) ? 2'b01 : 2'b10);
      e.fs  = (e.sym == 2'b10) && model_prev_mark;
      model_prev_mark = (e.sym == 2'b10);
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_pulse(input int hi, input int lo);
    int r;
    int f;
    @(negedge clk_10mhz);
    irigb = 1'b1;
    r = cyc;
    repeat (hi) @(negedge clk_10mhz);
    irigb = 1'b0;
    f = cyc;
    model_pulse(hi, r, f);
    repeat (lo) @(negedge clk_10mhz);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irigb = 1'b0;
    model_prev_mark = 1'b0;
    repeat (5) @(negedge clk_10mhz);
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid got %b expected 0", sym_valid); end
    checks++; if (sym !== 2'b00) begin errors++; $display("FAIL reset_sym got %b expected 00", sym); end
    checks++; if (sym_err !== 1'b0) begin errors++; $display("FAIL reset_sym_err got %b expected 0", sym_err); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b expected 0", frame_start); end
    // Pulse already high across reset release must be discarded.
    irigb = 1'b1;
    repeat (3) @(negedge clk_10mhz);
    rst_n = 1'b1;
    repeat (200) @(negedge clk_10mhz);
    irigb = 1'b0;
    repeat (20) @(negedge clk_10mhz);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL reset_preexisting_pulse got %0d strobes expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_symbols();
    drive_pulse(200, 800);
    drive_pulse(500, 800);
    drive_pulse(800, 800);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL symbols count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].fs !== exp_q[i].fs ||
          (!exp_q[i].is_err && obs_q[i].sym !== exp_q[i].sym)) begin
        errors++;
        $display("FAIL symbols ev%0d got cyc=%0d err=%0b sym=%b fs=%b expected cyc=%0d err=%0b sym=%b fs=%b", i,
                 obs_q[i].cyc, obs_q[i].is_err, obs_q[i].sym, obs_q[i].fs, exp_q[i].cyc, exp_q[i].is_err, exp_q[i].sym, exp_q[i].fs);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_start();
    int widths[8] = '{200, 500, 800, 800, 500, 800, 800, 800};
    foreach (widths[k]) drive_pulse(widths[k], 200);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL frame count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].fs !== exp_q[i].fs ||
          (!exp_q[i].is_err && obs_q[i].sym !== exp_q[i].sym)) begin
        errors++;
        $display("FAIL frame ev%0d got cyc=%0d err=%0b sym=%b fs=%b expected cyc=%0d err=%0b sym=%b fs=%b", i,
                 obs_q[i].cyc, obs_q[i].is_err, obs_q[i].sym, obs_q[i].fs, exp_q[i].cyc, exp_q[i].is_err, exp_q[i].sym, exp_q[i].fs);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stuck_high();
    drive_pulse(1200, 100);
    drive_pulse(200, 100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stuck count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].fs !== exp_q[i].fs ||
          (!exp_q[i].is_err && obs_q[i].sym !== exp_q[i].sym)) begin
        errors++;
        $display("FAIL stuck ev%0d got cyc=%0d err=%0b sym=%b fs=%b expected cyc=%0d err=%0b sym=%b fs=%b", i,
                 obs_q[i].cyc, obs_q[i].is_err, obs_q[i].sym, obs_q[i].fs, exp_q[i].cyc, exp_q[i].is_err, exp_q[i].sym, exp_q[i].fs);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    drive_pulse(1, 50);
    drive_pulse(200, 100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].fs !== exp_q[i].fs ||
          (!exp_q[i].is_err && obs_q[i].sym !== exp_q[i].sym)) begin
        errors++;
        $display("FAIL glitch ev%0d got cyc=%0d err=%0b sym=%b fs=%b expected cyc=%0d err=%0b sym=%b fs=%b", i,
                 obs_q[i].cyc, obs_q[i].is_err, obs_q[i].sym, obs_q[i].fs, exp_q[i].cyc, exp_q[i].is_err, exp_q[i].sym, exp_q[i].fs);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_pulse();
    drive_pulse(800, 100);
    @(negedge clk_10mhz);
    irigb = 1'b1;
    repeat (400) @(negedge clk_10mhz);
    rst_n = 1'b0;
    model_prev_mark = 1'b0;
    repeat (3) @(negedge clk_10mhz);
    checks++;
    if (sym_valid !== 1'b0 || sym_err !== 1'b0 || sym !== 2'b00 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b sym=%b err=%b fs=%b expected 0 00 0 0", sym_valid, sym, sym_err, frame_start);
    end
    rst_n = 1'b1;
    repeat (397) @(negedge clk_10mhz);
    irigb = 1'b0;
    repeat (100) @(negedge clk_10mhz);
    drive_pulse(200, 100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].fs !== exp_q[i].fs ||
          (!exp_q[i].is_err && obs_q[i].sym !== exp_q[i].sym)) begin
        errors++;
        $display("FAIL midreset ev%0d got cyc=%0d err=%0b sym=%b fs=%b expected cyc=%0d err=%0b sym=%b fs=%b", i,
                 obs_q[i].cyc, obs_q[i].is_err, obs_q[i].sym, obs_q[i].fs, exp_q[i].cyc, exp_q[i].is_err, exp_q[i].sym, exp_q[i].fs);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int bnd[10] = '{1, T_MIN - 1, T_MIN, T_01 - 1, T_01, T_1M - 1, T_1M, T_MAX - 1, T_MAX, T_MAX + 1};
    int w;
    foreach (bnd[k]) drive_pulse(bnd[k], $urandom_range(8, 40));
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) w = bnd[$urandom_range(0, 9)];
      else w = $urandom_range(1, T_MAX + 100);
      drive_pulse(w, $urandom_range(8, 40));
    end
    repeat (20) @(negedge clk_10mhz);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].fs !== exp_q[i].fs ||
          (!exp_q[i].is_err && obs_q[i].sym !== exp_q[i].sym)) begin
        errors++;
        $display("FAIL random ev%0d got cyc=%0d err=%0b sym=%b fs=%b expected cyc=%0d err=%0b sym=%b fs=%b", i,
                 obs_q[i].cyc, obs_q[i].is_err, obs_q[i].sym, obs_q[i].fs, exp_q[i].cyc, exp_q[i].is_err, exp_q[i].sym, exp_q[i].fs);
      end
    end
    obs_q.delete(); exp_q.delete();
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL valid_err_overlap got %0d cycles expected 0", overlap_cnt); end
    checks++; if (hold_viol_cnt != 0) begin errors++; $display("FAIL sym_hold got %0d changes expected 0", hold_viol_cnt); end
    checks++; if (orphan_fs_cnt != 0) begin errors++; $display("FAIL frame_start_alone got %0d cycles expected 0", orphan_fs_cnt); end
  endtask

  initial begin
    test_reset();
    test_symbols();
    test_frame_start();
    test_stuck_high();
    test_glitch();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
